// File: rtl/riscv_gpio_pkg.sv
// Shared register offsets and defaults for the GPIO peripheral.
package riscv_gpio_pkg;

  localparam logic [4:0] OFS_OUT  = 5'h00;
  localparam logic [4:0] OFS_IN   = 5'h04;
  localparam logic [4:0] OFS_EDGE = 5'h08;
  localparam logic [4:0] OFS_MASK = 5'h0C;
  localparam logic [4:0] OFS_DIV  = 5'h10;

  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd999;

  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/riscv_gpio_io_debounce.sv
// One input bit: 2-flop synchroniser, tick-sampled history, debounced level.
module gpio_debounce #(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic sw_i,
  output logic in_o,
  output logic in_next_o
);

  logic [1:0]             sync_q;
  logic [DEB_SAMPLES-1:0] hist_q, hist_d;
  logic                   in_q, in_d;

  always_comb begin
    hist_d = hist_q;
    if (tick_i) hist_d = {hist_q[DEB_SAMPLES-2:0], sync_q[1]};
    // A mixed history holds the previously accepted level.
    in_d = in_q;
    if (&hist_q)       in_d = 1'b1;
    else if (~|hist_q) in_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= '0;
      in_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      hist_q <= hist_d;
      in_q   <= in_d;
    end
  end

  assign in_o      = in_q;
  assign in_next_o = in_d;

endmodule

// File: rtl/riscv_gpio_io.sv
// Memory-mapped GPIO: LED outputs, debounced SW inputs, rising-edge status
// with per-bit interrupt mask and a shared sample-tick divider.
module riscv_gpio_io
  import riscv_gpio_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEB_SAMPLES = 3,
  parameter logic [15:0] DIV_RESET   = DIV_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [3:0]        bus_be,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] LED,
  output logic              irq
);

  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] w1c;
  logic [15:0]       div_q, div_d, cnt_q, cnt_d;
  logic [31:0]       div_wr;
  logic [31:0]       rdata_q, rd_mux;
  logic              rvalid_q, irq_q;
  logic              tick;
  logic [4:0]        word_addr;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];
  assign word_addr       = {bus_addr[4:2], 2'b00};
  assign tick            = (cnt_q == 16'd0);

  for (genvar i = 0; i < DATA_W; i++) begin : g_deb
    gpio_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk_i     (clk),
      .rst_ni    (rst),
      .tick_i    (tick),
      .sw_i      (SW[i]),
      .in_o      (in_q[i]),
      .in_next_o (in_d[i])
    );
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    div_d  = div_q;
    w1c    = '0;
    div_wr = apply_be({16'd0, div_q}, bus_wdata, bus_be);
    if (bus_wr) begin
      unique case (word_addr)
        OFS_OUT:  out_d  = DATA_W'(apply_be(32'(out_q), bus_wdata, bus_be));
        OFS_MASK: mask_d = DATA_W'(apply_be(32'(mask_q), bus_wdata, bus_be));
        OFS_EDGE: w1c    = DATA_W'(bus_wdata & be_mask(bus_be));
        OFS_DIV:  div_d  = div_wr[15:0];
        default:  ;
      endcase
    end

    // A DIV write restarts the count; otherwise reload only at terminal count.
    if (bus_wr && word_addr == OFS_DIV) cnt_d = div_d;
    else if (tick)                      cnt_d = div_q;
    else                                cnt_d = cnt_q - 16'd1;

    // New rising edges win over a simultaneous write-1-to-clear.
    edge_d = (edge_q & ~w1c) | (in_d & ~in_q);

    unique case (word_addr)
      OFS_OUT:  rd_mux = 32'(out_q);
      OFS_IN:   rd_mux = 32'(in_q);
      OFS_EDGE: rd_mux = 32'(edge_q);
      OFS_MASK: rd_mux = 32'(mask_q);
      OFS_DIV:  rd_mux = {16'd0, div_q};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q    <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      div_q    <= DIV_RESET;
      cnt_q    <= DIV_RESET;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      rvalid_q <= bus_rd;
      if (bus_rd) rdata_q <= rd_mux;
      irq_q    <= |(edge_q & mask_q);
    end
  end

  assign LED        = out_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule
